// File: rtl/cpu_pkg.sv
// Shared arbiter constants and state encoding for the mux4 port arbiter.
package cpu_pkg;

   localparam int NREQ  = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arbState_e;

   function automatic logic [NREQ-1:0] oneHot(input logic [SEL_W-1:0] idx);
      return NREQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotated priority encoder: first requester after ptr_i (wrapping, ptr_i itself last).
module rr_pick4
   import cpu_pkg::*;
(
   input  logic [NREQ-1:0]  req_i,
   input  logic [SEL_W-1:0] ptr_i,
   output logic             found_o,
   output logic [SEL_W-1:0] idx_o
);

   logic [SEL_W-1:0] cand;

   // Walk lowest priority first so the highest-priority hit is written last.
   always_comb begin
      found_o = 1'b0;
      idx_o   = ptr_i;
      cand    = ptr_i;
      for (int k = NREQ; k >= 1; k--) begin
         cand = ptr_i + SEL_W'(k);
         if (req_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/mux4_arb.sv
// Round-robin arbiter driving the shared mux4 select; define MUX4_ARB_HOLD_EN
// for sticky bursts bounded by last_i and HOLD_MAX, otherwise one beat per grant.
module mux4_arb
   import cpu_pkg::*;
#(
   parameter int HOLD_MAX = 4
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [NREQ-1:0]  req_i,
   input  logic [NREQ-1:0]  last_i,
   input  logic             rdy_i,
   output logic [NREQ-1:0]  gnt_o,
   output logic [SEL_W-1:0] sel_o,
   output logic             valid_o
);

   arbState_e        state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic             pickFound;
   logic [SEL_W-1:0] pickIdx;
   logic             beat;
   logic             burstEnd;
   logic             term;

`ifdef MUX4_ARB_HOLD_EN
   localparam int CNT_W = $clog2(HOLD_MAX) + 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   logic [CNT_W-1:0] beatCnt_q, beatCnt_d;

   assign burstEnd = last_i[sel_q] || (beatCnt_q == HOLD_LAST);
`else
   localparam int unusedHoldMax = HOLD_MAX;
   logic unusedLast;

   assign unusedLast = ^last_i;
   assign burstEnd   = 1'b1;
`endif

   // ptr_q equals sel_q while granted, so one picker serves both IDLE and handover.
   rr_pick4 uPick (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .found_o (pickFound),
      .idx_o   (pickIdx)
   );

   assign valid_o = gnt_q[sel_q] & req_i[sel_q];
   assign beat    = valid_o & rdy_i;
   assign term    = (state_q == GRANT) && (!req_i[sel_q] || (beat && burstEnd));
   assign gnt_o   = gnt_q;
   assign sel_o   = sel_q;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
`ifdef MUX4_ARB_HOLD_EN
      beatCnt_d = beatCnt_q;
`endif
      if ((state_q == IDLE) || term) begin
         if (pickFound) begin
            state_d = GRANT;
            ptr_d   = pickIdx;
            sel_d   = pickIdx;
            gnt_d   = oneHot(pickIdx);
`ifdef MUX4_ARB_HOLD_EN
            beatCnt_d = '0;
`endif
         end else begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      end
`ifdef MUX4_ARB_HOLD_EN
      else if (beat) begin
         beatCnt_d = beatCnt_q + CNT_W'(1);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= 2'b11;
         sel_q   <= '0;
         gnt_q   <= '0;
`ifdef MUX4_ARB_HOLD_EN
         beatCnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
`ifdef MUX4_ARB_HOLD_EN
         beatCnt_q <= beatCnt_d;
`endif
      end
   end

endmodule
